// File: rtl/lsu.sv
// Load/store unit: accepts one op at a time from EXE, writes ALU results back
// directly, and runs RV32I loads/stores through a valid/ready request channel
// followed by a single-cycle response.
module lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_load,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [31:0]           in_addr,
  input  logic [31:0]           in_wdata,
  input  logic [31:0]           in_alu_data,
  input  logic [ADDR_WIDTH-1:0] in_rd_addr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_wen,
  output logic [31:0]           mem_req_addr,
  output logic [31:0]           mem_req_wdata,
  output logic [3:0]            mem_req_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_rdata,
  output logic                  rd_wen,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  misalign
);

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic alu_fire, bad_fire, mem_fire, req_done, resp_fire;
  logic mem_op, both_op, ld_illegal, st_illegal, mis_addr, bad_op;

  logic [3:0]            st_strb;
  logic [WORD_W-1:0]     st_data;
  logic [WORD_W-1:0]     ld_shift;
  logic [WORD_W-1:0]     ld_data;

  // Captured op context for the response phase
  logic                  ld_q;
  logic [2:0]            funct3_q;
  logic [1:0]            lane_q;
  logic [ADDR_WIDTH-1:0] rd_q;

  // Ready only while idle; reset forces it low even though the FSM sits in IDLE
  assign in_ready = rst_n && (state_q == IDLE);

  // Classify the offered op
  assign mem_op     = in_is_load | in_is_store;
  assign both_op    = in_is_load & in_is_store;
  assign ld_illegal = in_is_load &&
                      ((in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111));
  assign st_illegal = in_is_store && (in_funct3[2] || (in_funct3 == 3'b011));
  assign mis_addr   = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                      ((in_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
  assign bad_op     = both_op | ld_illegal | st_illegal | mis_addr;

  // Lane-align store data and strobes
  always_comb begin
    st_strb = 4'b1111;
    st_data = in_wdata;
    case (in_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << in_addr[1:0];
        st_data = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << in_addr[1:0];
        st_data = {2{in_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Extract and extend the loaded lane from the response word
  assign ld_shift = mem_resp_rdata >> {lane_q, 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b100:  ld_data = {24'h000000, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b101:  ld_data = {16'h0000, ld_shift[15:0]};
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and per-cycle event decode
  always_comb begin
    state_d   = state_q;
    alu_fire  = 1'b0;
    bad_fire  = 1'b0;
    mem_fire  = 1'b0;
    req_done  = 1'b0;
    resp_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (!mem_op) begin
            alu_fire = 1'b1;
          end else if (bad_op) begin
            bad_fire = 1'b1;
          end else begin
            mem_fire = 1'b1;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          req_done = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          resp_fire = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: request channel, write-back port and exception pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      rd_wen        <= 1'b0;
      rd_addr_o     <= '0;
      rd_data_o     <= '0;
      misalign      <= 1'b0;
      ld_q          <= 1'b0;
      funct3_q      <= '0;
      lane_q        <= '0;
      rd_q          <= '0;
    end else begin
      rd_wen   <= 1'b0;
      misalign <= bad_fire;

      if (alu_fire) begin
        rd_wen    <= (in_rd_addr != '0);
        rd_addr_o <= in_rd_addr;
        rd_data_o <= DATA_WIDTH'(in_alu_data);
      end

      if (mem_fire) begin
        mem_req_valid <= 1'b1;
        mem_req_wen   <= in_is_store;
        mem_req_addr  <= {in_addr[31:2], 2'b00};
        mem_req_wdata <= in_is_store ? st_data : '0;
        mem_req_wstrb <= in_is_store ? st_strb : 4'b0000;
        ld_q          <= in_is_load;
        funct3_q      <= in_funct3;
        lane_q        <= in_addr[1:0];
        rd_q          <= in_rd_addr;
      end else if (req_done) begin
        mem_req_valid <= 1'b0;
      end

      if (resp_fire && ld_q) begin
        rd_wen    <= (rd_q != '0);
        rd_addr_o <= rd_q;
        rd_data_o <= DATA_WIDTH'(ld_data);
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus pushes expected write-backs, misalign
// pulses and memory requests; a negedge monitor pops and compares them.
module tb_lsu;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_is_load = 1'b0;
  logic          in_is_store = 1'b0;
  logic [2:0]    in_funct3 = '0;
  logic [31:0]   in_addr = '0;
  logic [31:0]   in_wdata = '0;
  logic [31:0]   in_alu_data = '0;
  logic [AW-1:0] in_rd_addr = '0;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_wen;
  logic [31:0]   mem_req_addr;
  logic [31:0]   mem_req_wdata;
  logic [3:0]    mem_req_wstrb;
  logic          mem_resp_valid;
  logic [31:0]   mem_resp_rdata;
  logic          rd_wen;
  logic [AW-1:0] rd_addr_o;
  logic [DW-1:0] rd_data_o;
  logic          misalign;

  lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_alu_data(in_alu_data), .in_rd_addr(in_rd_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .rd_wen(rd_wen), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } rd_t;

  req_t        req_q[$];
  rd_t         rd_q[$];
  int          mis_q[$];
  logic [31:0] resp_q[$];

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;   // 0 random, 1 held low, 2 held high
  bit resp_en = 1'b1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none", name);
  endfunction

  // Offer one op; push expectations from the reference rules once it is accepted
  task automatic issue(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] alu, input logic [4:0] rd,
                       input logic [31:0] resp, input bit expect_rd, output int waited);
    bit ok;
    bit legal;
    int nbytes;
    int lane;
    logic [31:0] strb, sdata, lval, mask, shifted;
    in_valid    = 1'b1;
    in_is_load  = (kind == 1) || (kind == 3);
    in_is_store = (kind == 2) || (kind == 3);
    in_funct3   = f3;
    in_addr     = addr;
    in_wdata    = wdata;
    in_alu_data = alu;
    in_rd_addr  = rd;
    waited = 0;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for 300 cycles, expected 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    nbytes = 1 << f3[1:0];
    lane   = int'(addr % 4);
    if (kind == 0) begin
      if (rd != 0) rd_q.push_back('{a: rd, d: alu});
    end else begin
      legal = (kind != 3) && ((addr % nbytes) == 0);
      if (kind == 1) legal = legal && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (kind == 2) legal = legal && (f3 inside {3'd0, 3'd1, 3'd2});
      if (!legal) begin
        mis_q.push_back(1);
      end else begin
        strb  = ((32'd1 << nbytes) - 1) << lane;
        sdata = '0;
        for (int i = 0; i < 4; i++)
          sdata = sdata | (((wdata >> (8 * (i % nbytes))) & 32'hFF) << (8 * i));
        req_q.push_back('{addr: addr & 32'hFFFF_FFFC, wen: (kind == 2),
                          wdata: (kind == 2) ? sdata : 32'h0,
                          wstrb: (kind == 2) ? strb[3:0] : 4'h0});
        resp_q.push_back(resp);
        if (kind == 1 && rd != 0 && expect_rd) begin
          shifted = resp >> (8 * lane);
          lval = shifted;
          if (nbytes < 4) begin
            mask = (32'd1 << (8 * nbytes)) - 1;
            lval = shifted & mask;
            if (!f3[2] && lval[8 * nbytes - 1]) lval = lval | ~mask;
          end
          rd_q.push_back('{a: rd, d: lval});
        end
      end
    end
    #1;
  endtask

  // Monitor: every output event must match the head of its expectation queue
  initial begin
    rd_t  er;
    req_t eq;
    forever begin
      @(negedge clk);
      if (rd_wen) begin
        if (rd_q.size() == 0) fail_event("unexpected_rd_wen");
        else begin
          er = rd_q.pop_front();
          chk("rd_addr", 32'(rd_addr_o), 32'(er.a));
          chk("rd_data", rd_data_o, er.d);
        end
      end
      if (misalign) begin
        if (mis_q.size() == 0) fail_event("unexpected_misalign");
        else begin
          void'(mis_q.pop_front());
          chk("misalign_no_req", 32'(mem_req_valid), 32'd0);
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (req_q.size() == 0) fail_event("unexpected_mem_req");
        else begin
          eq = req_q.pop_front();
          chk("req_addr", mem_req_addr, eq.addr);
          chk("req_wen", 32'(mem_req_wen), 32'(eq.wen));
          chk("req_wdata", mem_req_wdata, eq.wdata);
          chk("req_wstrb", 32'(mem_req_wstrb), 32'(eq.wstrb));
        end
      end
    end
  end

  // Memory model: drives ready, answers each handshake after a random delay,
  // and injects stray response pulses when nothing is outstanding
  initial begin
    bit hs_prev = 1'b0;
    bit pending = 1'b0;
    int delay = 0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      if (hs_prev) begin
        pending = 1'b1;
        delay   = $urandom_range(0, 3);
      end
      if (pending) begin
        if (resp_en) begin
          if (delay == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = (resp_q.size() != 0) ? resp_q.pop_front() : $urandom;
            pending = 1'b0;
          end else begin
            delay--;
          end
        end
      end else begin
        mem_resp_rdata = $urandom;
        if (rdy_mode == 0 && ($urandom % 4) == 0) mem_resp_valid = 1'b1;
      end
      mem_req_ready = (rdy_mode == 1) ? 1'b0 : (rdy_mode == 2) ? 1'b1 : (($urandom % 3) != 0);
      hs_prev = mem_req_valid && mem_req_ready;
    end
  end

  // Stimulus: reset, directed scenarios, then a random mix
  initial begin
    int w;
    bit done;
    logic prev_resp;
    int kind;
    logic [31:0] a;

    #12;
    chk("reset_outputs",
        32'({in_ready, mem_req_valid, mem_req_wen, mem_req_wstrb, rd_wen, misalign}), 32'd0);
    chk("reset_req_addr", mem_req_addr, 32'd0);
    chk("reset_rd_data", rd_data_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // ALU write-back
    issue(0, 3'd0, 32'h0, 32'h0, 32'h0000_1234, 5'd5, 32'h0, 1'b1, w);
    // Byte loads from lane 3, signed and unsigned
    rdy_mode = 2;
    issue(1, 3'b000, 32'h0000_0103, 32'h0, 32'h0, 5'd6, 32'h80FF_0000, 1'b1, w);
    issue(1, 3'b100, 32'h0000_0103, 32'h0, 32'h0, 5'd6, 32'h80FF_0000, 1'b1, w);
    // Halfword store to the upper half
    issue(2, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 5'd3, 32'h0, 1'b1, w);
    // Misaligned word load
    issue(1, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 5'd4, 32'h0, 1'b1, w);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("misalign_req_valid", 32'(mem_req_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Ready held low: request fields stay put, in_ready returns after the response
    rdy_mode = 1;
    issue(1, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 5'd9, 32'h1122_3344, 1'b1, w);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(mem_req_valid), 32'd1);
      chk("stall_addr", mem_req_addr, 32'h0000_0040);
      chk("stall_wen_wstrb", 32'({mem_req_wen, mem_req_wstrb}), 32'd0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    rdy_mode = 2;
    prev_resp = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        chk("ready_after_resp", 32'(prev_resp), 32'd1);
        done = 1'b1;
        break;
      end
      prev_resp = mem_resp_valid;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ready_return_timeout: got in_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;

    // Back-to-back ALU ops, including rd=0
    for (int i = 0; i < 8; i++) begin
      issue(0, 3'd0, 32'h0, 32'h0, $urandom, 5'(i), 32'h0, 1'b1, w);
      chk("alu_b2b_wait", 32'(w), 32'd0);
    end
    in_valid = 1'b0;

    // Reset while waiting for a response; the late response must be dropped
    resp_en = 1'b0;
    issue(1, 3'b010, 32'h0000_0300, 32'h0, 32'h0, 5'd7, 32'hDEAD_BEEF, 1'b0, w);
    in_valid = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!mem_req_valid && !in_ready) begin
        done = 1'b1;
        break;
      end
    end
    chk("reached_wait", 32'(done), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs",
        32'({in_ready, mem_req_valid, mem_req_wen, mem_req_wstrb, rd_wen, misalign}), 32'd0);
    chk("midreset_addr", mem_req_addr, 32'd0);
    chk("midreset_rd", 32'(rd_addr_o) | rd_data_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    repeat (10) @(negedge clk);
    chk("ready_after_midreset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Random mix
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom % 20;
      kind = (kind < 8) ? 0 : (kind < 14) ? 1 : (kind < 19) ? 2 : 3;
      a = $urandom;
      if ($urandom % 2) a[1:0] = 2'b00;
      issue(kind, 3'($urandom), a, $urandom, $urandom, 5'($urandom), $urandom, 1'b1, w);
      if (($urandom % 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;

    repeat (40) @(negedge clk);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("mis_queue_drained", 32'(mis_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, the register and memory data width; ADDR_WIDTH, default 5, the register index width.
REQ-002 Port list SHALL be, in order:
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  EXE offers an op.
- in_ready  out  1  LSU can accept an op.
- in_is_load  in  1  op is a load.
- in_is_store  in  1  op is a store.
- in_funct3  in  3  RV32I width/sign code.
- in_addr  in  32  effective byte address.
- in_wdata  in  32  store data (rs2).
- in_alu_data  in  32  result to write back for non-memory ops.
- in_rd_addr  in  ADDR_WIDTH  destination register.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_wen  out  1  1 = write.
- mem_req_addr  out  32  word-aligned address.
- mem_req_wdata  out  32  lane-aligned store data.
- mem_req_wstrb  out  4  byte strobes.
- mem_resp_valid  in  1  response valid, one cycle.
- mem_resp_rdata  in  32  read word.
- rd_wen  out  1  register-file write enable.
- rd_addr_o  out  ADDR_WIDTH  register-file write index.
- rd_data_o  out  DATA_WIDTH  register-file write data.
- misalign  out  1  one-cycle exception pulse.

Function
REQ-003 The FSM SHALL have three states: IDLE, REQ and WAIT.
REQ-004 in_ready SHALL be 1 only in IDLE with rst_n high; an op is accepted on in_valid && in_ready.
REQ-005 A non-memory op accepted at cycle T SHALL give, at T+1: rd_wen=1, rd_addr_o=in_rd_addr, rd_data_o=in_alu_data; the FSM stays in IDLE.
REQ-006 A memory op SHALL be misaligned when: LH/LHU/SH and addr[0]=1; LW/SW and addr[1:0]!=0.
REQ-007 A load SHALL be illegal when funct3 is 011, 110 or 111.
REQ-008 A store SHALL be illegal when funct3[2]=1 or funct3=011.
REQ-009 A misaligned or illegal memory op accepted at T SHALL pulse misalign=1 at T+1, issue no memory request, leave rd_wen=0, and keep the FSM in IDLE.
REQ-010 A legal memory op accepted at T SHALL move the FSM to REQ; from T+1, mem_req_valid=1 and all request fields are registered and stable until mem_req_ready.
REQ-011 mem_req_addr SHALL be {in_addr[31:2],2'b00}; mem_req_wen = in_is_store.
REQ-012 Store strobes SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
REQ-013 Store data SHALL be: SB byte replicated 4 times; SH halfword replicated twice; SW unchanged.
REQ-014 For a load, mem_req_wstrb SHALL be 0.
REQ-015 On a cycle in REQ with mem_req_ready=1, mem_req_valid SHALL drop next cycle and the FSM SHALL enter WAIT; while ready is low the FSM SHALL stay in REQ.
REQ-016 mem_resp_valid SHALL be ignored in every state except WAIT.
REQ-017 In WAIT, mem_resp_valid at cycle R SHALL return the FSM to IDLE at R+1 (in_ready=1 at R+1).
REQ-018 For a load, rd_wen=1 at R+1 with rd_data_o extracted from lane addr[1:0]: LB/LH sign-extended, LBU/LHU zero-extended, LW the full word.
REQ-019 A store SHALL complete on its response with no register write.
REQ-020 rd_wen SHALL be a one-cycle pulse and SHALL never assert when the destination index is 0 (rd_addr_o/rd_data_o still update).
REQ-021 in_is_load and in_is_store both 1 SHALL be treated as illegal (misalign pulse, no request).
REQ-022 Exactly one op SHALL be outstanding at a time; back-to-back non-memory ops SHALL sustain one per cycle.

Reset
REQ-023 While rst_n=0, all outputs SHALL be 0, including in_ready, and the FSM SHALL be in IDLE.
REQ-024 Reset mid-transaction SHALL abandon the op: mem_req_valid drops immediately, no rd write occurs, and any later response is ignored.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- ALU op rd=5, data 0x1234 -> rd_wen=1 one cycle after accept, rd_addr_o=5, rd_data_o=0x1234.
- LB addr 0x103, resp 0x80FF_0000 -> request addr 0x100, rd_data_o=0xFFFF_FF80; same with LBU -> 0x0000_0080.
- SH addr 0x202, wdata 0xABCD -> wstrb 4'b1100, wdata 0xABCD_ABCD, wen=1, no rd_wen.
- LW addr 0x101 -> misalign pulse one cycle after accept, mem_req_valid stays 0.
- mem_req_ready held low 3 cycles -> request fields stable; in_ready=0 until the cycle after mem_resp_valid.
- rst_n low during WAIT -> outputs 0 asynchronously; a response after reset release produces no rd_wen.
